hv_timing_gen: RTL



---
 rtl/hv_timing_pkg.sv | 36 +++
 rtl/hv_delay_line.sv | 44 ++++
 rtl/hv_timing_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hv_timing_pkg.sv
// ---------------------------------------------------------------------------
// hv_timing_pkg
// Shared types and limits for the hv_timing_gen raster generator.
//   calc_tot    : total pixels/lines = active + front porch + sync + back porch
//   ADJ_W       : width of the signed sync-shift inputs
//   MAX_TOT     : largest supported H/V total (counters are CNT_W bits)
//   MAX_LAT     : deepest supported pixel-pipeline delay
//   dl_entry_t  : one delay-line slot {hb, vb, hs, vs, ls, fs}
//   DL_IDLE     : blanked, sync inactive, no start pulses
// ---------------------------------------------------------------------------
package hv_timing_pkg;

    localparam int ADJ_W   = 4;
    localparam int MAX_TOT = 512;
    localparam int MAX_LAT = 7;
    localparam int CNT_W   = $clog2(MAX_TOT);

    // hs/vs are active-high here; the top inverts them onto HSYN/VSYN.
    typedef struct packed {
        logic hb;
        logic vb;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } dl_entry_t;

    localparam dl_entry_t DL_IDLE = '{hb: 1'b1, vb: 1'b1, hs: 1'b0,
                                      vs: 1'b0, ls: 1'b0, fs: 1'b0};

    function automatic int calc_tot(input int act, input int fp,
                                    input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/hv_delay_line.sv
// ---------------------------------------------------------------------------
// hv_delay_line
// Shift register of dl_entry_t that advances only on i_ce. Matches the raw
// blank/sync decode to the game core's pixel pipeline depth.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset, clears every slot to DL_IDLE
//   i_ce   : pixel clock enable
//   i_d    : raw decoded entry
//   o_q    : entry delayed by DEPTH pixel enables (DEPTH=0: combinational)
// ---------------------------------------------------------------------------
module hv_delay_line
    import hv_timing_pkg::*;
#(
    parameter int DEPTH = 1
)(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_ce,
    input  dl_entry_t i_d,
    output dl_entry_t o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_ce};
            assign o_q      = i_d;
        end else begin : g_sr
            dl_entry_t r_sr [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= DL_IDLE;
                end else if (i_ce) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/hv_timing_gen.sv
// ---------------------------------------------------------------------------
// hv_timing_gen
// Raster timing generator: pixel clock enable, H/V position counters,
// pipeline-aligned blank/sync and RGB gating for an arcade core.
//   clk_sys     : system clock
//   RESET       : synchronous active-high reset
//   h_adj/v_adj : signed sync shift (pixels/lines), latched at frame start
//   ce_pix      : pixel enable, one clk_sys wide, every CE_DIV cycles
//   HPOS/VPOS   : current pixel position, (0,0) is first active pixel
//   iRGB/oRGB   : core pixel in / gated pixel out (black while blanked)
//   HBLK/VBLK   : blanking, active high
//   HSYN/VSYN   : sync, active low
//   line_start/frame_start : one-ce pulses, pipeline aligned
// Build option: define HVGEN_ADJ_EN to enable the h_adj/v_adj sync shift;
// otherwise the adjust inputs are ignored and sync is at nominal position.
// ---------------------------------------------------------------------------
module hv_timing_gen
    import hv_timing_pkg::*;
#(
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 44,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 21,
    parameter int CE_DIV   = 8,
    parameter int PIX_LAT  = 1,
    parameter int RGB_W    = 12
)(
    input  logic             clk_sys,
    input  logic             RESET,
    input  logic [ADJ_W-1:0] h_adj,
    input  logic [ADJ_W-1:0] v_adj,
    output logic             ce_pix,
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    input  logic [RGB_W-1:0] iRGB,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT = calc_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W = $clog2(CE_DIV);
    // Two spare bits so sync-window arithmetic never wraps.
    localparam int SW    = CNT_W + 2;

    logic [DIV_W-1:0]        r_div;
    logic [CNT_W-1:0]        r_hcnt;
    logic [CNT_W-1:0]        r_vcnt;
    logic                    w_ce;
    logic signed [ADJ_W-1:0] w_hadj_l;
    logic signed [ADJ_W-1:0] w_vadj_l;
    logic [SW-1:0]           w_hs0;
    logic [SW-1:0]           w_vs0;
    logic [SW-1:0]           w_hx;
    logic [SW-1:0]           w_vx;
    dl_entry_t               w_raw;
    dl_entry_t               w_dly;

    assign w_ce   = (r_div == DIV_W'(CE_DIV - 1));
    assign ce_pix = w_ce;
    assign HPOS   = r_hcnt;
    assign VPOS   = r_vcnt;

    always_ff @(posedge clk_sys) begin
        if (RESET) r_div <= '0;
        else       r_div <= w_ce ? '0 : r_div + 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_ce) begin
            if (r_hcnt == CNT_W'(H_TOT - 1)) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == CNT_W'(V_TOT - 1)) ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

`ifdef HVGEN_ADJ_EN
    logic signed [ADJ_W-1:0] r_hadj;
    logic signed [ADJ_W-1:0] r_vadj;

    // Captured once per frame so a mid-frame change cannot tear the sync.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_hadj <= '0;
            r_vadj <= '0;
        end else if (w_ce && r_hcnt == '0 && r_vcnt == '0) begin
            r_hadj <= $signed(h_adj);
            r_vadj <= $signed(v_adj);
        end
    end

    assign w_hadj_l = r_hadj;
    assign w_vadj_l = r_vadj;
`else
    logic w_unused_adj;
    assign w_unused_adj = ^{h_adj, v_adj};
    assign w_hadj_l     = '0;
    assign w_vadj_l     = '0;
`endif

    // Sync start moves opposite to the adjust sign (positive = earlier);
    // the sized cast of the signed adjust sign-extends it.
    assign w_hs0 = SW'(H_ACTIVE + H_FP) - SW'(w_hadj_l);
    assign w_vs0 = SW'(V_ACTIVE + V_FP) - SW'(w_vadj_l);
    assign w_hx  = {2'b00, r_hcnt};
    assign w_vx  = {2'b00, r_vcnt};

    always_comb begin
        w_raw    = DL_IDLE;
        w_raw.hb = (r_hcnt >= CNT_W'(H_ACTIVE));
        w_raw.vb = (r_vcnt >= CNT_W'(V_ACTIVE));
        w_raw.hs = (w_hx >= w_hs0) && (w_hx < w_hs0 + SW'(H_SYNC));
        w_raw.vs = (w_vx >= w_vs0) && (w_vx < w_vs0 + SW'(V_SYNC));
        w_raw.ls = (r_hcnt == '0);
        w_raw.fs = (r_hcnt == '0) && (r_vcnt == '0);
    end

    hv_delay_line #(.DEPTH(PIX_LAT)) u_dly (
        .i_clk (clk_sys),
        .i_rst (RESET),
        .i_ce  (w_ce),
        .i_d   (w_raw),
        .o_q   (w_dly)
    );

    // Output register adds the final ce of latency and keeps every output
    // except ce_pix changing only on pixel enables.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            HBLK        <= 1'b1;
            VBLK        <= 1'b1;
            HSYN        <= 1'b1;
            VSYN        <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            oRGB        <= '0;
        end else if (w_ce) begin
            HBLK        <= w_dly.hb;
            VBLK        <= w_dly.vb;
            HSYN        <= ~w_dly.hs;
            VSYN        <= ~w_dly.vs;
            line_start  <= w_dly.ls;
            frame_start <= w_dly.fs;
            oRGB        <= (w_dly.hb | w_dly.vb) ? '0 : iRGB;
        end
    end

endmodule
